// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues in-order fetches, buffers {instr, pc+4} in a DEPTH-entry FIFO.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_incr,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Stale-response counter is wider: back-to-back redirects can leave more than DEPTH responses to discard.
  localparam int DW = CW + 4;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]     occupancy, inflight;
  logic [DW-1:0]     drop_cnt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic head_valid, accept, resp_drop, resp_live, resp_taken, bypass, push, pop_fifo;
  logic [CW:0] credit_used;

  assign credit_used = {1'b0, occupancy} + {1'b0, inflight};
  assign imem_req    = rst && !redirect && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign head_valid  = (occupancy != '0);
  assign resp_drop   = imem_rvalid && (drop_cnt != '0);
  assign resp_live   = imem_rvalid && (drop_cnt == '0) && (inflight != '0) && !redirect;
  assign resp_taken  = imem_rvalid && ((drop_cnt != '0) || (inflight != '0));
  assign pop_fifo    = head_valid && id_ready;
`ifdef IFQ_BYPASS_EN
  assign bypass      = !head_valid && resp_live && id_ready;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = resp_live && !bypass;

  always_comb begin
    id_valid   = head_valid;
    id_instr   = head_valid ? instr_mem[rd_ptr] : '0;
    id_pc_incr = head_valid ? pc_mem[rd_ptr]    : '0;
    if (bypass) begin
      id_valid   = 1'b1;
      id_instr   = imem_rdata;
      id_pc_incr = resp_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      occupancy <= '0;
      inflight  <= '0;
      drop_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect) begin
      // Flush everything; every outstanding response becomes stale.
      fetch_pc  <= redirect_pc;
      resp_pc   <= redirect_pc;
      occupancy <= '0;
      inflight  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      drop_cnt  <= drop_cnt + DW'(inflight) - DW'(resp_taken);
    end else begin
      if (accept)           fetch_pc <= fetch_pc + ADDR_W'(4);
      if (resp_drop)        drop_cnt <= drop_cnt - DW'(1);
      if (resp_live)        resp_pc  <= resp_pc + ADDR_W'(4);
      if (push)             wr_ptr   <= wr_ptr + 1'b1;
      if (pop_fifo)         rd_ptr   <= rd_ptr + 1'b1;
      inflight  <= inflight + CW'(accept) - CW'(resp_live);
      occupancy <= occupancy + CW'(push) - CW'(pop_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc + ADDR_W'(4);
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && occupancy == CW'(DEPTH)));
`endif
endmodule
